// File: rtl/avalon_mem_slave.sv
// Avalon-MM memory slave: a data region and an instruction region, each 32 bits wide.
// It stalls each request for a programmable number of cycles and raises a sticky error on bad accesses.
module avalon_mem_slave #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] R0_BASE     = 32'h0000_0000,
  parameter int unsigned R0_WORDS    = 1024,
  parameter logic [31:0] R1_BASE     = 32'hBFC0_0000,
  parameter int unsigned R1_WORDS    = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        error
);

  localparam int unsigned AW0      = (R0_WORDS > 1) ? $clog2(R0_WORDS) : 1;
  localparam int unsigned AW1      = (R1_WORDS > 1) ? $clog2(R1_WORDS) : 1;
  localparam logic [3:0]  WAIT_MAX = 4'(WAIT_CYCLES);
  localparam logic [32:0] R0_END   = {1'b0, R0_BASE} + 33'(R0_WORDS) * 33'd4;
  localparam logic [32:0] R1_END   = {1'b0, R1_BASE} + 33'(R1_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCEPT
  } state_t;

  state_t         state, state_nxt;
  logic [3:0]     wcnt, wcnt_nxt;
  logic           pending, stall, complete;
  logic           hit0, hit1, sel0, sel1, bad;
  logic           wr_ok;
  logic [AW0-1:0] idx0;
  logic [AW1-1:0] idx1;

  logic [31:0] mem0 [R0_WORDS];
  logic [31:0] mem1 [R1_WORDS];

  // A request is stalled until wcnt has counted WAIT_CYCLES cycles.
  // wcnt never exceeds WAIT_MAX, so equality is the whole test.
  assign pending     = (read | write) & ~reset;
  assign stall       = pending & (wcnt != WAIT_MAX);
  assign waitrequest = reset | stall;
  assign complete    = pending & ~stall;

  // Region 1 takes priority when the two windows overlap.
  assign hit0 = (address >= R0_BASE) && ({1'b0, address} < R0_END);
  assign hit1 = (address >= R1_BASE) && ({1'b0, address} < R1_END);
  assign sel1 = hit1;
  assign sel0 = hit0 & ~hit1;
  assign idx0 = AW0'((address - R0_BASE) >> 2);
  assign idx1 = AW1'((address - R1_BASE) >> 2);
  assign bad  = (address[1:0] != 2'b00) | ~(hit0 | hit1) | (read & write);

  assign wr_ok = complete & write & ~bad;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    wcnt_nxt = 4'd0;
    if (stall) wcnt_nxt = wcnt + 4'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pending) state_nxt = (WAIT_MAX == 4'd0) ? S_ACCEPT : S_WAIT;
      S_WAIT: begin
        if (!pending)              state_nxt = S_IDLE;
        else if (wcnt == WAIT_MAX) state_nxt = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (pending) state_nxt = (WAIT_MAX == 4'd0) ? S_ACCEPT : S_WAIT;
        else         state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // NOTE: the memory arrays are deliberately not reset; reset must leave their contents intact.
  always_ff @(posedge clk) begin
    if (wr_ok && sel0) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem0[idx0][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && sel1) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem1[idx1][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  // A bad access zeroes readdata and latches error; a good write leaves readdata alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'h0;
      error    <= 1'b0;
    end else if (complete) begin
      if (bad) begin
        readdata <= 32'h0;
        error    <= 1'b1;
      end else if (read) begin
        readdata <= sel1 ? mem1[idx1] : mem0[idx0];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Directed bench for avalon_mem_slave: four instances, with WAIT_CYCLES = 0..3 (instance index = wait count).
// Each step drives the bus at the falling edge and compares outputs against hand-computed values.
module tb_avalon_mem_slave;

  logic        clk = 1'b0;
  logic        reset       [4];
  logic        read        [4];
  logic        write       [4];
  logic        waitrequest [4];
  logic        error       [4];
  logic [31:0] address     [4];
  logic [31:0] writedata   [4];
  logic [31:0] readdata    [4];
  logic [3:0]  byteenable  [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    avalon_mem_slave #(.WAIT_CYCLES(g)) dut (
      .clk        (clk),
      .reset      (reset[g]),
      .address    (address[g]),
      .read       (read[g]),
      .write      (write[g]),
      .writedata  (writedata[g]),
      .byteenable (byteenable[g]),
      .waitrequest(waitrequest[g]),
      .readdata   (readdata[g]),
      .error      (error[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after completion with the request still driven.
  task automatic xfer(input int n, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, output int cycles, output int stalls);
    bit done = 1'b0;
    cycles = 0;
    stalls = 0;
    address[n]    = a;
    writedata[n]  = d;
    byteenable[n] = be;
    read[n]       = rd;
    write[n]      = wr;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      cycles++;
      if (waitrequest[n]) stalls++;
      else done = 1'b1;
      @(negedge clk);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL xfer_timeout: instance %0d observed waitrequest stuck high, required completion within 20 cycles", n);
    end
  endtask

  task automatic idle(input int n);
    read[n]  = 1'b0;
    write[n] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_wr(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int c, s;
    xfer(n, 1'b0, 1'b1, a, d, be, c, s);
    idle(n);
  endtask

  task automatic do_rd(input int n, input logic [31:0] a, input logic [31:0] exp, input string tag);
    int c, s;
    xfer(n, 1'b1, 1'b0, a, 32'h0, 4'h0, c, s);
    idle(n);
    check(tag, readdata[n], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, required $finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    int c, s, total;
    logic [31:0] b2b [4];
    b2b = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};

    for (int i = 0; i < 4; i++) begin
      reset[i]      = 1'b1;
      read[i]       = 1'b0;
      write[i]      = 1'b0;
      address[i]    = 32'h0;
      writedata[i]  = 32'h0;
      byteenable[i] = 4'h0;
    end
    repeat (2) @(negedge clk);

    // Reset state
    check1("rst_wait0", waitrequest[0], 1'b1);
    check1("rst_wait3", waitrequest[3], 1'b1);
    check("rst_rdata3", readdata[3], 32'h0);
    check1("rst_err3", error[3], 1'b0);
    for (int i = 0; i < 4; i++) reset[i] = 1'b0;
    @(negedge clk);
    check1("idle_wait3", waitrequest[3], 1'b0);

    // Zero-wait write then read
    xfer(0, 1'b0, 1'b1, 32'h190, 32'd123, 4'hF, c, s);
    check("w190_stalls", 32'(s), 32'd0);
    idle(0);
    xfer(0, 1'b1, 1'b0, 32'h190, 32'h0, 4'h0, c, s);
    check("r190_stalls", 32'(s), 32'd0);
    idle(0);
    check("r190_data", readdata[0], 32'd123);

    // Byte lanes, empty byteenable
    do_wr(0, 32'h0, 32'h1122_3344, 4'hF);
    do_wr(0, 32'h0, 32'hAABB_CCDD, 4'b0101);
    do_rd(0, 32'h0, 32'h11BB_33DD, "lanes");
    do_wr(0, 32'h0, 32'hFFFF_FFFF, 4'b0000);
    check("be0_rdata_hold", readdata[0], 32'h11BB_33DD);
    check1("be0_err", error[0], 1'b0);
    do_rd(0, 32'h0, 32'h11BB_33DD, "be0_nochange");

    // Read immediately following a write to the same word
    xfer(0, 1'b0, 1'b1, 32'h8, 32'h55, 4'hF, c, s);
    xfer(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, c, s);
    idle(0);
    check("raw_data", readdata[0], 32'h55);

    // Region 0 upper boundary
    do_wr(0, 32'hFFC, 32'hCAFE_0001, 4'hF);
    do_rd(0, 32'hFFC, 32'hCAFE_0001, "r0_top");
    check1("r0_top_err", error[0], 1'b0);
    do_rd(0, 32'h1000, 32'h0, "r0_past_end");
    check1("r0_past_end_err", error[0], 1'b1);

    // Three-cycle stall on the instruction region
    xfer(3, 1'b0, 1'b1, 32'hBFC0_0000, 32'h8C01_0064, 4'hF, c, s);
    check("w_r1_stalls", 32'(s), 32'd3);
    idle(3);
    xfer(3, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, c, s);
    check("r_r1_stalls", 32'(s), 32'd3);
    check("r_r1_cycles", 32'(c), 32'd4);
    idle(3);
    check("r_r1_data", readdata[3], 32'h8C01_0064);
    do_wr(3, 32'hBFC0_0FFC, 32'h1234_5678, 4'hF);
    do_rd(3, 32'hBFC0_0FFC, 32'h1234_5678, "r1_top");
    check1("r1_top_err", error[3], 1'b0);

    // Abandoned request: drop read mid-stall
    address[3] = 32'h0;
    read[3]    = 1'b1;
    @(negedge clk);
    #1 check1("abandon_stall", waitrequest[3], 1'b1);
    read[3] = 1'b0;
    @(negedge clk);
    check1("abandon_err", error[3], 1'b0);
    check("abandon_rdata", readdata[3], 32'h1234_5678);
    xfer(3, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, c, s);
    check("after_abandon_stalls", 32'(s), 32'd3);
    idle(3);
    check("after_abandon_data", readdata[3], 32'h8C01_0064);
    do_rd(3, 32'hBFC0_1000, 32'h0, "r1_past_end");
    check1("r1_past_end_err", error[3], 1'b1);

    // Bad accesses and sticky error
    do_wr(1, 32'h0, 32'hDEAD_BEEF, 4'hF);
    do_rd(1, 32'h2, 32'h0, "misalign_rdata");
    check1("misalign_err", error[1], 1'b1);
    do_wr(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
    check1("unmapped_err", error[1], 1'b1);
    check("unmapped_rdata", readdata[1], 32'h0);
    do_wr(1, 32'h2, 32'h0, 4'hF);
    do_rd(1, 32'h0, 32'hDEAD_BEEF, "mem_unchanged");
    check1("err_sticky", error[1], 1'b1);
    reset[1] = 1'b1;
    @(negedge clk);
    check1("err_cleared", error[1], 1'b0);
    reset[1] = 1'b0;
    @(negedge clk);
    xfer(1, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF, c, s);
    idle(1);
    check1("rw_both_err", error[1], 1'b1);
    check("rw_both_rdata", readdata[1], 32'h0);
    do_rd(1, 32'h0, 32'hDEAD_BEEF, "rw_both_nowrite");

    // Back-to-back reads, one wait cycle each
    for (int i = 0; i < 4; i++) do_wr(1, 32'h10 + 32'(4 * i), b2b[i], 4'hF);
    total = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 4'h0, c, s);
      check("b2b_cycles", 32'(c), 32'd2);
      check("b2b_data", readdata[1], b2b[i]);
      total += c;
    end
    idle(1);
    check("b2b_total", 32'(total), 32'd8);

    // Reset during a stalled write
    do_wr(2, 32'h4, 32'd5, 4'hF);
    address[2]    = 32'h4;
    writedata[2]  = 32'd7;
    byteenable[2] = 4'hF;
    write[2]      = 1'b1;
    @(negedge clk);
    reset[2] = 1'b1;
    #1 check1("rst_mid_wait", waitrequest[2], 1'b1);
    @(negedge clk);
    check("rst_mid_rdata", readdata[2], 32'h0);
    check1("rst_mid_err", error[2], 1'b0);
    reset[2] = 1'b0;
    write[2] = 1'b0;
    @(negedge clk);
    xfer(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, c, s);
    check("post_rst_stalls", 32'(s), 32'd2);
    idle(2);
    check("post_rst_data", readdata[2], 32'd5);
    check1("post_rst_err", error[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
